// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch front-end for a single-cycle core. Owns the fetch PC, issues one
// request at a time to a variable-latency instruction memory (req/ack), and
// buffers returned words together with their PCs in a small FIFO that the
// core drains over a valid/ready interface. A redirect from the core flushes
// the buffer and retires any in-flight fetch without keeping its data.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   en           fetch enable (0 = no new requests)
//   redirect     core requests a PC change this cycle
//   redirect_pc  new fetch address (bits [1:0] forced to 00)
//   mem_req      instruction memory request (registered)
//   mem_addr     request address (registered)
//   mem_ack      memory returns mem_rdata this cycle, completes the request
//   mem_rdata    instruction word from memory
//   instr_valid  FIFO head holds an instruction
//   instr        head instruction word, 0 when empty
//   instr_pc     head instruction PC, 0 when empty
//   instr_ready  core consumes the head this cycle
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // DISCARD: a request is still outstanding but its data must be dropped
    // because a redirect arrived while it was pending.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT    = 2'b01,
        S_DISCARD = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_valid;
    logic [31:0]   w_redirect_pc;

    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_valid       = (r_count != {CW{1'b0}});

    // Next-state, next fetch PC and FIFO push/flush decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                end else if (en && (r_count < CW'(DEPTH))) begin
                    // Occupancy before any same-edge pop decides issue.
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = w_redirect_pc;
                end else begin
                    w_fetch_pc_nxt = r_fetch_pc;
                end
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DISCARD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Redirect outranks consumption: the core's ready is ignored that edge.
    assign w_pop = w_valid && instr_ready && !redirect;

    // Control state, fetch PC and the registered memory request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_mem_req  <= (w_state_nxt != S_IDLE);
            // While a request is pending the address stays latched even if
            // a redirect moves the fetch PC underneath it.
            if (w_state_nxt == S_IDLE) begin
                r_mem_addr <= w_fetch_pc_nxt;
            end else if (r_state == S_IDLE) begin
                r_mem_addr <= r_fetch_pc;
            end else begin
                r_mem_addr <= r_mem_addr;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (w_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    // FIFO storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
            r_fifo_data[r_wr_ptr] <= mem_rdata;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_fifo_data[r_rd_ptr] : 32'h0000_0000;
    assign instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A transaction-level model (fetch PC,
// one outstanding-request flag, a drop flag and a queue of {pc, word}) tracks
// what the outputs must be and is compared every cycle; literal expectations
// from hand-worked timelines pin the model itself.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NO_ENTRY = 32'hBAD0_BAD1;

    logic        clk;
    logic        reset;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory responder controls
    bit auto_mem = 1'b1;
    int lat      = 1;
    int mcnt     = 0;

    // Observation logs
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic        prev_req = 1'b0;

    // Model state
    logic [31:0] m_fpc;
    logic [31:0] m_raddr;
    bit          m_busy;
    bit          m_drop;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_w[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : NO_ENTRY;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : NO_ENTRY;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_fpc   = RESET_PC;
        m_raddr = RESET_PC;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        mq_pc.delete();
        mq_w.delete();
    endtask

    // Behaviour at one rising edge, from the fetch rules.
    task automatic model_update();
        int sz;
        if (reset) begin
            m_reset();
        end else begin
            sz = mq_pc.size();
            if (redirect) begin
                mq_pc.delete();
                mq_w.delete();
                m_fpc = {redirect_pc[31:2], 2'b00};
                if (m_busy) begin
                    if (mem_ack) begin
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end else begin
                if (sz != 0 && instr_ready) begin
                    void'(mq_pc.pop_front());
                    void'(mq_w.pop_front());
                end
                if (m_busy) begin
                    if (mem_ack) begin
                        if (!m_drop) begin
                            mq_pc.push_back(m_raddr);
                            mq_w.push_back(mem_rdata);
                            m_fpc = m_raddr + 32'd4;
                        end
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end
                end else if (en && sz < DEPTH) begin
                    m_busy  = 1'b1;
                    m_raddr = m_fpc;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_pc;
        logic [31:0] e_w;
        e_pc = (mq_pc.size() != 0) ? mq_pc[0] : 32'h0;
        e_w  = (mq_w.size()  != 0) ? mq_w[0]  : 32'h0;
        check("mem_req",     {31'd0, mem_req},     {31'd0, m_busy});
        check("mem_addr",    mem_addr,             m_busy ? m_raddr : m_fpc);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, (mq_pc.size() != 0)});
        check("instr",       instr,                e_w);
        check("instr_pc",    instr_pc,             e_pc);
    endtask

    // Memory answers after 'lat' cycles of request, with the word for mem_addr.
    task automatic respond();
        if (auto_mem) begin
            if (mem_req) begin
                mcnt++;
                if (mcnt >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word_of(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = ~mem_addr;
                end
            end else begin
                mcnt      = 0;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
        end
    endtask

    task automatic step();
        if (instr_valid && instr_ready && !redirect && !reset) pop_log.push_back(instr_pc);
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        if (mem_req && !prev_req) req_log.push_back(mem_addr);
        prev_req = mem_req;
        respond();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        auto_mem = 1'b1;
        mcnt     = 0;
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b0;
        m_reset();

        // Reset state
        step();
        check("rst_mem_req",  {31'd0, mem_req},     32'd0);
        check("rst_mem_addr", mem_addr,             RESET_PC);
        check("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check("rst_instr",    instr,                32'h0);
        check("rst_instr_pc", instr_pc,             32'h0);

        // Streaming fetch, ack one cycle after request
        do_reset();
        en = 1'b1; instr_ready = 1'b1; lat = 1;
        step();
        check("t1_first_req", {31'd0, mem_req}, 32'd1);
        step();
        check("t1_first_valid", {31'd0, instr_valid}, 32'd1);
        check("t1_first_pc",    instr_pc,             32'h0);
        check("t1_first_word",  instr,                32'h1357_9BDF);
        step_n(6);
        check("t1_req0", req_at(0), 32'h0);
        check("t1_req1", req_at(1), 32'h4);
        check("t1_req2", req_at(2), 32'h8);
        check("t1_pop0", pop_at(0), 32'h0);
        check("t1_pop1", pop_at(1), 32'h4);
        check("t1_pop2", pop_at(2), 32'h8);

        // Back-pressure fills the FIFO, then drains
        do_reset();
        en = 1'b1; instr_ready = 1'b0; lat = 1;
        step_n(8);
        check("t2_nreq",   32'(req_log.size()),  32'd2);
        check("t2_req_lo", {31'd0, mem_req},     32'd0);
        check("t2_valid",  {31'd0, instr_valid}, 32'd1);
        check("t2_headpc", instr_pc,             32'h0);
        instr_ready = 1'b1;
        step_n(8);
        check("t2_pop0", pop_at(0), 32'h0);
        check("t2_pop1", pop_at(1), 32'h4);
        check("t2_req2", req_at(2), 32'h8);

        // Redirect while waiting on address 8
        do_reset();
        en = 1'b1; instr_ready = 1'b0; lat = 1;
        step_n(6);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0; lat = 3;
        step();
        check("t3_wait_addr", mem_addr, 32'h8);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        check("t3_flushed",   {31'd0, instr_valid}, 32'd0);
        check("t3_disc_req",  {31'd0, mem_req},     32'd1);
        check("t3_disc_addr", mem_addr,             32'h8);
        clear_logs();
        instr_ready = 1'b1;
        step_n(14);
        check("t3_req0", req_at(0), 32'h0000_0100);
        check("t3_pop0", pop_at(0), 32'h0000_0100);

        // Redirect on the same edge as the ack
        do_reset();
        en = 1'b1; instr_ready = 1'b1; lat = 2;
        step_n(2);
        check("t4_ack_up", {31'd0, mem_ack}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0;
        check("t4_req_lo", {31'd0, mem_req},     32'd0);
        check("t4_valid",  {31'd0, instr_valid}, 32'd0);
        check("t4_addr",   mem_addr,             32'h0000_0040);
        clear_logs();
        step_n(8);
        check("t4_req0", req_at(0), 32'h0000_0040);
        check("t4_pop0", pop_at(0), 32'h0000_0040);

        // PC wrap
        do_reset();
        en = 1'b1; instr_ready = 1'b1; lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        clear_logs();
        step_n(8);
        check("t5_req0", req_at(0), 32'hFFFF_FFFC);
        check("t5_req1", req_at(1), 32'h0000_0000);
        check("t5_pop0", pop_at(0), 32'hFFFF_FFFC);
        check("t5_pop1", pop_at(1), 32'h0000_0000);

        // Reset while waiting; late ack ignored
        do_reset();
        en = 1'b1; instr_ready = 1'b1; lat = 5;
        step_n(2);
        check("t6_waiting", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check("t6_req_drop", {31'd0, mem_req}, 32'd0);
        check("t6_addr_rst", mem_addr,         RESET_PC);
        auto_mem = 1'b0; en = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        reset = 1'b0;
        step_n(2);
        check("t6_late_ack", {31'd0, instr_valid}, 32'd0);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        auto_mem = 1'b1; mcnt = 0; lat = 1; en = 1'b1;
        clear_logs();
        step_n(4);
        check("t6_req0", req_at(0), RESET_PC);
        check("t6_pop0", pop_at(0), RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the single-cycle CPU datapath/decoder.
- Owns the fetch PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready interface.
- Core branch/jump redirects flush the buffer and discard any in-flight fetch.

Parameters:
RESET_PC, 32'h00000000, fetch PC loaded on reset; bits [1:0] must be 0
DEPTH, 2, FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  fetch enable; 0 = issue no new requests (sleep)
redirect  input  1  core requests PC change (taken branch/jump)
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 00)
mem_req  output  1  instruction memory request
mem_addr  output  32  request address (= fetch_pc)
mem_ack  input  1  memory has valid mem_rdata this cycle, completes request
mem_rdata  input  32  instruction word
instr_valid  output  1  FIFO head holds a valid instruction
instr  output  32  head instruction word; 0 when empty
instr_pc  output  32  head instruction PC; 0 when empty
instr_ready  input  1  core consumes head this cycle

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC, state=IDLE, FIFO empty, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. Reset mid-request aborts it; ack arriving later is ignored (state IDLE).
- FSM states: IDLE, WAIT, DISCARD. mem_req=1 in WAIT and DISCARD, else 0 (registered).
- IDLE→WAIT: en=1, redirect=0, FIFO count<DEPTH (count after same-edge pop not considered).
- WAIT: mem_req and mem_addr held stable until mem_ack sampled high.
- WAIT, ack, no redirect: push {fetch_pc, mem_rdata}; fetch_pc+=4; →IDLE. One request outstanding max; no back-to-back issue, so best throughput is 1 instr / 2 cycles.
- WAIT, redirect, no ack: flush FIFO; fetch_pc=redirect_pc; →DISCARD (mem_addr stays the old address until ack — mem_addr = latched request address while req high).
- WAIT, redirect and ack same edge: data dropped, flush, fetch_pc=redirect_pc, →IDLE.
- DISCARD: keep req high; on ack drop data, →IDLE. Redirect in DISCARD: update fetch_pc, stay DISCARD.
- Redirect in IDLE: flush, fetch_pc=redirect_pc, stay IDLE; issue resumes next edge.
- Redirect priority: beats push and pop; instr_ready ignored on redirect edge.
- FIFO: pop on instr_valid&&instr_ready; push+pop same edge keeps count; pop when empty ignored; push only when not full (guaranteed by issue rule).
- en=0: no new issue; outstanding request completes normally; FIFO still drains.
- PC arithmetic mod 2^32: 32'hFFFFFFFC+4 = 0. Head outputs combinational from FIFO; instr_valid = count≠0.

Test Plan:
- Reset with RESET_PC=0, en=1, memory ack 1 cycle after req, instr_ready=1 → reqs at 0,4,8; instr_pc sequence 0,4,8 with matching words; first instr_valid on edge after first ack.
- instr_ready=0, DEPTH=2 → exactly 2 fetches (0,4) buffered, mem_req stays 0; raise ready → drains 0 then 4, fetch of 8 issues.
- Redirect to 32'h00000103 while WAIT on addr 8 (ack 3 cycles later) → FIFO empties, ack'd word for 8 discarded, next req at 32'h00000100.
- Redirect and mem_ack same edge → returned word never appears; next req at redirect_pc.
- Redirect to 32'hFFFFFFFC → fetches FFFFFFFC then 00000000.
- Assert reset while WAIT → mem_req=0 immediately; late ack ignored; after release first req at RESET_PC.
